// File: rtl/garage_pkg.sv
// Shared definitions for the garage gate decoder and the occupancy counter.
package garage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IN_A,
    IN_AB,
    IN_B,
    OUT_B,
    OUT_AB,
    OUT_A,
    WAIT_CLEAR
  } gate_state_t;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  localparam int GARAGE_CAPACITY = 50;

  // States in which a car is mid-passage and the state timer runs.
  function automatic logic is_passage(gate_state_t s);
    return (s != IDLE) && (s != WAIT_CLEAR);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a debouncer: the filtered value flips only
// after the synchronized input has disagreed with it for DEBOUNCE_CYCLES cycles.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      filtered <= 1'b0;
      cnt      <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // Any cycle of agreement restarts the stability count.
      if (sync_p1 != filtered) begin
        if (cnt == CNT_LAST) begin
          filtered <= sync_p1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/garage_gate_decoder.sv
// Decodes the two gate beams into one registered count pulse per completed
// passage, with direction, full/empty refusal and illegal-sequence detection.
module garage_gate_decoder
  import garage_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  input  logic garage_full,
  input  logic garage_empty,
  output logic open_button,
  output logic car_in_out,
  output logic reject,
  output logic fault,
  output logic busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic        a;
  logic        b;
  logic [1:0]  ab;
  gate_state_t state;
  gate_state_t next_state;
  logic [TW-1:0] timer;
  logic        timeout;
  logic        open_nx;
  logic        reject_nx;
  logic        fault_nx;
  logic        dir_nx;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk      (clk),
    .reset    (reset),
    .raw      (sensor_a),
    .filtered (a)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk      (clk),
    .reset    (reset),
    .raw      (sensor_b),
    .filtered (b)
  );

  assign ab      = {a, b};
  assign timeout = is_passage(state) && (timer == TIMER_LAST);

  // State, timer and all outputs are registered so every pulse is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      open_button <= 1'b0;
      reject      <= 1'b0;
      fault       <= 1'b0;
      car_in_out  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= next_state;
      open_button <= open_nx;
      reject      <= reject_nx;
      fault       <= fault_nx;
      car_in_out  <= dir_nx;
      busy        <= (next_state != IDLE);
      if ((next_state != state) || !is_passage(next_state)) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    if (timeout) begin
      next_state = WAIT_CLEAR;
    end else begin
      unique case (state)
        IDLE: begin
          case (ab)
            2'b10:   next_state = garage_full  ? WAIT_CLEAR : IN_A;
            2'b01:   next_state = garage_empty ? WAIT_CLEAR : OUT_B;
            2'b11:   next_state = WAIT_CLEAR;
            default: next_state = state;
          endcase
        end
        IN_A: begin
          case (ab)
            2'b11:   next_state = IN_AB;
            2'b00:   next_state = IDLE;
            2'b01:   next_state = WAIT_CLEAR;
            default: next_state = state;
          endcase
        end
        IN_AB: begin
          case (ab)
            2'b01:   next_state = IN_B;
            2'b10:   next_state = IN_A;
            2'b00:   next_state = IDLE;
            default: next_state = state;
          endcase
        end
        IN_B: begin
          case (ab)
            2'b00:   next_state = IDLE;
            2'b11:   next_state = IN_AB;
            2'b10:   next_state = WAIT_CLEAR;
            default: next_state = state;
          endcase
        end
        OUT_B: begin
          case (ab)
            2'b11:   next_state = OUT_AB;
            2'b00:   next_state = IDLE;
            2'b10:   next_state = WAIT_CLEAR;
            default: next_state = state;
          endcase
        end
        OUT_AB: begin
          case (ab)
            2'b10:   next_state = OUT_A;
            2'b01:   next_state = OUT_B;
            2'b00:   next_state = IDLE;
            default: next_state = state;
          endcase
        end
        OUT_A: begin
          case (ab)
            2'b00:   next_state = IDLE;
            2'b11:   next_state = OUT_AB;
            2'b01:   next_state = WAIT_CLEAR;
            default: next_state = state;
          endcase
        end
        WAIT_CLEAR: begin
          if (ab == 2'b00) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Pulses are derived from the transition taken, so at most one fires per cycle.
  always_comb begin
    open_nx   = 1'b0;
    reject_nx = 1'b0;
    fault_nx  = 1'b0;
    dir_nx    = car_in_out;
    if (timeout) begin
      fault_nx = 1'b1;
    end else if (state == IDLE) begin
      if (next_state == IN_A)  dir_nx = DIR_IN;
      if (next_state == OUT_B) dir_nx = DIR_OUT;
      if (next_state == WAIT_CLEAR) begin
        reject_nx = (ab != 2'b11);
        fault_nx  = (ab == 2'b11);
      end
    end else if (next_state != state) begin
      open_nx  = (next_state == IDLE) && ((state == IN_B) || (state == OUT_A));
      fault_nx = (next_state == WAIT_CLEAR) ||
                 ((next_state == IDLE) && ((state == IN_AB) || (state == OUT_AB)));
    end
  end

endmodule

// File: tb/tb_garage_gate_decoder.sv
// Directed bench for garage_gate_decoder with a queue-based pulse scoreboard.
module tb_garage_gate_decoder;

  localparam int EV_OPEN   = 0;
  localparam int EV_REJECT = 1;
  localparam int EV_FAULT  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensor_a = 1'b0;
  logic sensor_b = 1'b0;
  logic garage_full = 1'b0;
  logic garage_empty = 1'b0;
  logic open_button;
  logic car_in_out;
  logic reject;
  logic fault;
  logic busy;

  garage_gate_decoder #(
    .DEBOUNCE_CYCLES (4),
    .TIMEOUT_CYCLES  (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sensor_a     (sensor_a),
    .sensor_b     (sensor_b),
    .garage_full  (garage_full),
    .garage_empty (garage_empty),
    .open_button  (open_button),
    .car_in_out   (car_in_out),
    .reject       (reject),
    .fault        (fault),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   kind;
    logic dir;
    int   at;
  } ev_t;

  ev_t sb[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(int kind, logic dir, int at);
    ev_t e;
    e.kind = kind;
    e.dir  = dir;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic drive(logic a, logic b, int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops one expected event for every pulse the DUT presents.
  ev_t m_e;
  int  m_kind;
  always @(posedge clk) begin
    #1;
    if (open_button || reject || fault) begin
      m_kind = open_button ? EV_OPEN : (reject ? EV_REJECT : EV_FAULT);
      check("pulse_onehot", int'(open_button) + int'(reject) + int'(fault), 1);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", m_kind, cyc);
      end else begin
        m_e = sb.pop_front();
        check("pulse_kind", m_kind, m_e.kind);
        check("pulse_dir", int'(car_in_out), int'(m_e.dir));
        check("pulse_cycle", cyc, m_e.at);
      end
    end
  end

  int t;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_open", open_button, 0);
    check("rst_dir", car_in_out, 0);
    check("rst_reject", reject, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 0);

    // Full entry.
    drive(1, 0, 10);
    check("entry_dir_in_a", car_in_out, 1);
    check("entry_busy_in_a", busy, 1);
    drive(1, 1, 10);
    drive(0, 1, 10);
    t = cyc;
    expect_ev(EV_OPEN, 1'b1, t + 7);
    drive(0, 0, 12);
    check("entry_busy_after", busy, 0);
    check("entry_dir_held", car_in_out, 1);

    // Full exit.
    drive(0, 1, 10);
    check("exit_dir_out_b", car_in_out, 0);
    drive(1, 1, 10);
    drive(1, 0, 10);
    t = cyc;
    expect_ev(EV_OPEN, 1'b0, t + 7);
    drive(0, 0, 12);
    check("exit_busy_after", busy, 0);

    // Abort: car backs off from the outer beam.
    drive(1, 0, 10);
    drive(0, 0, 12);
    check("abort1_busy", busy, 0);
    check("abort1_dir", car_in_out, 1);

    // Abort: car reaches both beams then backs out.
    drive(1, 0, 10);
    drive(1, 1, 10);
    drive(1, 0, 10);
    drive(0, 0, 12);
    check("abort2_busy", busy, 0);

    // Entry refused while full.
    garage_full = 1'b1;
    t = cyc;
    expect_ev(EV_REJECT, 1'b1, t + 7);
    drive(1, 0, 10);
    drive(1, 1, 10);
    drive(0, 1, 10);
    check("full_busy_wait", busy, 1);
    drive(0, 0, 12);
    check("full_busy_after", busy, 0);
    garage_full = 1'b0;

    // Exit refused while empty; direction must stay as it was.
    garage_empty = 1'b1;
    t = cyc;
    expect_ev(EV_REJECT, 1'b1, t + 7);
    drive(0, 1, 10);
    drive(1, 1, 10);
    drive(1, 0, 10);
    drive(0, 0, 12);
    check("empty_busy_after", busy, 0);
    check("empty_dir_kept", car_in_out, 1);
    garage_empty = 1'b0;

    // Short sensor_b glitches in IN_A must not disturb the state timer.
    t = cyc;
    expect_ev(EV_FAULT, 1'b1, t + 27);
    drive(1, 0, 5);
    drive(1, 1, 3);
    drive(1, 0, 4);
    drive(1, 1, 3);
    drive(1, 0, 20);
    check("timeout_wait_clear", busy, 1);
    drive(0, 0, 12);
    check("timeout_busy_after", busy, 0);

    // Both beams at once from IDLE is illegal.
    t = cyc;
    expect_ev(EV_FAULT, 1'b1, t + 7);
    drive(1, 1, 10);
    check("both_busy", busy, 1);
    drive(0, 0, 12);
    check("both_busy_after", busy, 0);

    // Reset while in IN_B abandons the passage silently.
    drive(1, 0, 10);
    drive(1, 1, 10);
    drive(0, 1, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_open", open_button, 0);
    check("midrst_dir", car_in_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fault", fault, 0);
    drive(0, 1, 10);
    drive(0, 0, 12);
    check("midrst_busy_after", busy, 0);
    check("midrst_dir_after", car_in_out, 0);

    drive(0, 0, 20);
    check("events_outstanding", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/garage_gate_decoder.md
# garage_gate_decoder

- Sits directly upstream of the garage occupancy counter and turns two raw beam sensors at the gate into one count event per car that passes completely.
- Decodes the order in which the beams are broken to get the direction (in or out).
- Drives the counter's `Open_Button` event input and `car_in_out` direction input.
- Refuses entries when the garage is full and exits when it is empty.
- Flags sensor sequences that are illegal or take too long.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a filtered sensor value changes.
- `TIMEOUT_CYCLES`, default 1000: maximum cycles a car may stay in any one passage state.

Ports:
- `clk`  in  1  single clock; all flops are on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `sensor_a`  in  1  outer beam; 1 = blocked; asynchronous.
- `sensor_b`  in  1  inner beam; 1 = blocked; asynchronous.
- `garage_full`  in  1  occupancy is at capacity (50).
- `garage_empty`  in  1  occupancy is 0.
- `open_button`  out  1  one-cycle pulse: a car has completed a passage.
- `car_in_out`  out  1  direction of the current or last passage; 1 = in, 0 = out.
- `reject`  out  1  one-cycle pulse: entry refused while full, or exit refused while empty.
- `fault`  out  1  one-cycle pulse: illegal sensor sequence or timeout.
- `busy`  out  1  level; high in every state except IDLE.

## Operation
**Input filtering**
- Each sensor goes through a 2-FF synchronizer and then a debouncer.
- The filtered value `a`/`b` flips only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
- Any cycle where it agrees again clears the debounce counter.

**FSM states:** IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, WAIT_CLEAR. Transitions use the filtered pair {a,b}.
- **IDLE**
  - 10: go to IN_A and set `car_in_out`=1. If `garage_full`, pulse `reject` and go to WAIT_CLEAR instead.
  - 01: go to OUT_B and set `car_in_out`=0. If `garage_empty`, pulse `reject` and go to WAIT_CLEAR instead.
  - 11: pulse `fault`, go to WAIT_CLEAR.
- **IN_A**
  - 11: go to IN_AB.
  - 00: return to IDLE silently (car backed off).
  - 01: pulse `fault`, go to WAIT_CLEAR.
- **IN_AB**
  - 01: go to IN_B.
  - 10: go to IN_A.
  - 00: pulse `fault`, go to IDLE.
- **IN_B**
  - 00: pulse `open_button` and go to IDLE (entry counted).
  - 11: go to IN_AB.
  - 10: pulse `fault`, go to WAIT_CLEAR.
- **OUT_B / OUT_AB / OUT_A:** mirror image of the IN states with a and b swapped. OUT_A on 00 pulses `open_button` (exit counted).
- **WAIT_CLEAR:** go to IDLE only on 00. No pulses are produced here.
- In every state, an unchanged {a,b} keeps the current state.

**Timeout**
- A state timer runs in the six passage states and clears on every state change.
- When it reaches `TIMEOUT_CYCLES`-1: pulse `fault`, go to WAIT_CLEAR.

**Output rules**
- `car_in_out` changes only on IDLE→IN_A or IDLE→OUT_B. It is stable long before the matching `open_button` edge and is held afterwards.
- `garage_full`/`garage_empty` are sampled only on the IDLE exit transition.
- At most one of `open_button`, `reject`, `fault` is high in any cycle.

## Timing
- **Reset:** state IDLE; all outputs 0, including `car_in_out`=0; timer, debounce counters and synchronizers cleared; filtered `a`=`b`=0. Reset in the middle of a passage abandons it with no pulse.
- **Latency:** a raw sensor edge that stays stable reaches the filtered value `2+DEBOUNCE_CYCLES` edges later. The FSM reacts one edge after that, so `open_button` rises `3+DEBOUNCE_CYCLES` edges after the final raw clear.
- **Pulse width:** `open_button`, `reject` and `fault` are each exactly 1 cycle, registered, and glitch-free. This is required because the downstream counter uses `open_button` as its event edge.
- **Glitch rejection:** a raw glitch shorter than `DEBOUNCE_CYCLES` cycles has no effect.
- **Timer width:** $clog2(`TIMEOUT_CYCLES`). `busy` is registered from the state.

## Structure
- Shared package `garage_pkg`:
  - state enum;
  - `DIR_IN`=1, `DIR_OUT`=0;
  - `GARAGE_CAPACITY`=50 (shared with the occupancy counter).
- Sub-module `sensor_debounce`: 2-FF synchronizer plus debounce counter, parameter `DEBOUNCE_CYCLES`. It is instantiated twice, once per sensor.

## Test plan
- Full entry, each raw step held 10 cycles, `DEBOUNCE_CYCLES`=4.
  - Stimulus: a=1; a=1,b=1; b=1; both clear.
  - Required: `car_in_out`=1 from IN_A onward; a single `open_button` pulse 7 edges after the final clear; `busy` low afterwards.
- Mirror exit sequence with `garage_empty`=0: `car_in_out`=0 and one `open_button` pulse.
- Aborts:
  - a=1, then a=0: no pulse; back in IDLE.
  - a=1, a=1,b=1, then b=0 and a=0: no pulse; back in IDLE.
- Full and empty refusal:
  - `garage_full`=1 plus an entry sequence: one `reject` pulse, no `open_button`, wait for 00.
  - Same for an exit with `garage_empty`=1.
- Illegal sequences:
  - 3-cycle glitches on `sensor_b` while in IN_A: ignored.
  - IDLE→11: `fault`.
  - `TIMEOUT_CYCLES`=20 with a held at 1: `fault` at the 20th cycle in IN_A, then WAIT_CLEAR until 00.
- Assert `reset` in IN_B for one cycle: all outputs 0 on the next edge and no `open_button` pulse.
